wbuf_loader: RTL
================

# wbuf_loader

Write-side sequencer for the weight buffer. It accepts a descriptor (base row, row count) and a valid/ready stream of `MEM_DATA_WIDTH` words from the DMA/stream path. It emits the `mem_write_req`/`mem_write_addr`/`mem_write_data` sequence that scatters one full buffer row across every bank, in bank-ID order. It sits between the DMA read channel and the weight buffer's memory write port.

## Interface

**Parameters**
- `MEM_DATA_WIDTH`, default 64: stream and write word width.
- `ARRAY_N`, default 64: array rows.
- `ARRAY_M`, default 64: array columns.
- `DATA_WIDTH`, default 16: element width.
- `BUF_ADDR_WIDTH`, default 9: per-bank row address width.
- `GROUP_SIZE`, derived `(DATA_WIDTH*ARRAY_M)/MEM_DATA_WIDTH`: banks per array row.
- `NUM_BANKS`, derived `ARRAY_N*GROUP_SIZE`: words per buffer row. Must be a power of two.
- `BUF_ID_W`, derived `$clog2(ARRAY_N)` plus (`GROUP_SIZE==1 ? 0 : $clog2(GROUP_SIZE)`).
- `MEM_ADDR_WIDTH`, derived `BUF_ADDR_WIDTH+BUF_ID_W`.

**Ports**
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cfg_start` in 1: descriptor strobe. Accepted only in IDLE.
- `cfg_base_addr` in `BUF_ADDR_WIDTH`: first row.
- `cfg_num_rows` in `BUF_ADDR_WIDTH+1`: rows to load. 0 is legal.
- `busy` out 1: high while in LOAD.
- `done` out 1: one-cycle pulse when the descriptor completes.
- `s_valid` in 1: stream word valid.
- `s_data` in `MEM_DATA_WIDTH`: stream word.
- `s_ready` out 1: equals `busy`.
- `mem_write_req` out 1: registered write strobe.
- `mem_write_addr` out `MEM_ADDR_WIDTH`: `{row, bank_id}`. When `BUF_ID_W==0`, it is `row` only.
- `mem_write_data` out `MEM_DATA_WIDTH`: registered copy of the accepted word.

## Operation

- **States:** IDLE and LOAD.
- **IDLE → LOAD:** on `cfg_start` when `cfg_num_rows != 0`.
  - Latch `row = cfg_base_addr`, `rows_left = cfg_num_rows`, `bank = 0`.
- **Zero rows:** `cfg_start` with `cfg_num_rows == 0` stays in IDLE, pulses `done` next cycle, issues no writes.
- **Beat:** a beat is accepted when `s_valid && s_ready`.
  - Each beat writes `s_data` to `{row, bank}`, then `bank` increments.
  - When `bank == NUM_BANKS-1`: `bank` wraps to 0, `row` increments modulo `2^BUF_ADDR_WIDTH` (wraps silently), `rows_left` decrements.
  - Bank order is 0..NUM_BANKS-1, matching bank ID `m + n*GROUP_SIZE`.
- **LOAD → IDLE:** on the beat with `bank == NUM_BANKS-1 && rows_left == 1`. `done` is registered with the final write.
- **Start while busy:** `cfg_start` in LOAD is ignored. Descriptor inputs are don't-care outside an accepted start.
- **Reset** (including mid-LOAD):
  - State returns to IDLE; counters clear.
  - `mem_write_req`, `done`, `busy`, `s_ready` read 0 on the cycle after reset is sampled.
  - A partially loaded descriptor is abandoned. No further writes.
- **Reset values:** `mem_write_req=0`, `mem_write_addr=0`, `mem_write_data=0`, `busy=0`, `s_ready=0`, `done=0`.

## Timing

- Start accepted at cycle t → `busy`/`s_ready` high from t+1.
- Beat accepted at cycle k → `mem_write_req` high at k+1 with that beat's address and data. Latency is exactly 1 cycle.
- No beat at k → `mem_write_req=0` at k+1. Gaps in `s_valid` never reorder or skip addresses.
- Final beat at k → `done`=1 and the last write both at k+1. `busy`/`s_ready` are low at k+1.
- A new `cfg_start` is accepted at k+1.
- Zero-row start at t → `done` at t+1.
- Sustained throughput is one word per cycle. There is no internal backpressure beyond state.

## Structure

- A shared include/package `wbuf_params` holds the derived-parameter expressions: `GROUP_SIZE`, `NUM_BANKS`, `BUF_ID_W`, `MEM_ADDR_WIDTH`. The weight buffer and this loader must agree on them exactly.
- It also holds the state encodings (IDLE=0, LOAD=1).
- Sub-module: `wbuf_addr_gen` holds the bank/row/rows_left counters and the last-beat flag, driven by an `advance` input.
- The top level holds the FSM and the output registers built from `register_sync`.

## Test plan

All scenarios use `ARRAY_N=4`, `ARRAY_M=8`, `DATA_WIDTH=16`, `MEM_DATA_WIDTH=64`, `BUF_ADDR_WIDTH=4`. This gives `GROUP_SIZE=2`, `NUM_BANKS=8`, `BUF_ID_W=3`, `MEM_ADDR_WIDTH=7`.

1. **Basic load.** base=2, rows=1, 8 back-to-back beats with data 0xA0..0xA7 → writes to addr 16..23 with matching data on consecutive cycles. `done` coincides with addr 23. `busy` drops on the same cycle.
2. **Stream gaps.** Same descriptor, `s_valid` toggling 1,0,1,1,0,… → `mem_write_req` mirrors accepted beats one cycle later. Addresses are still 16..23 in order; no writes on gap cycles.
3. **Row wrap.** base=15, rows=2, 16 beats → addresses 120..127, then 0..7. `done` with addr 7.
4. **Zero rows.** rows=0 at cycle t → `done` at t+1. No `mem_write_req`; `busy` never asserts.
5. **Reset mid-load.** Reset asserted after 3 beats → next cycle all outputs 0. A new start with base=0, rows=1 writes addr 0..7 starting from bank 0.
6. **Start handling.** `cfg_start` pulsed mid-LOAD → ignored, current addresses unaffected. A new start on the `done` cycle is accepted, and its first write appears 2 cycles after that start.

Source files
------------

// File: rtl/wbuf_params.sv
// wbuf_params: derived weight-buffer geometry shared with the weight buffer, plus loader FSM states
package wbuf_params;
  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;
  function automatic int group_size(input int array_m, input int data_width, input int mem_data_width);
    return (data_width * array_m) / mem_data_width;
  endfunction
  function automatic int num_banks(input int array_n, input int gs);
    return array_n * gs;
  endfunction
  function automatic int buf_id_w(input int array_n, input int gs);
    return $clog2(array_n) + (gs == 1 ? 0 : $clog2(gs));
  endfunction
  function automatic int mem_addr_width(input int buf_addr_width, input int id_w);
    return buf_addr_width + id_w;
  endfunction
endpackage

// File: rtl/register_sync.sv
// register_sync: enabled register, sync active-high reset to 0; ports clk, reset, en, d -> q
module register_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/wbuf_addr_gen.sv
// wbuf_addr_gen: bank/row/rows_left counters; load latches a descriptor, advance steps one beat, last flags the final beat
module wbuf_addr_gen #(
  parameter int NUM_BANKS      = 8,
  parameter int BUF_ID_W       = 3,
  parameter int BUF_ADDR_WIDTH = 4,
  localparam int BW            = BUF_ID_W == 0 ? 1 : BUF_ID_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [BUF_ADDR_WIDTH-1:0] base,
  input  logic [BUF_ADDR_WIDTH:0]   num_rows,
  input  logic                      advance,
  output logic [BW-1:0]             bank,
  output logic [BUF_ADDR_WIDTH-1:0] row,
  output logic                      last
);
  logic [BUF_ADDR_WIDTH:0] rows_left;
  logic                    row_end;
  assign row_end = bank == BW'(NUM_BANKS - 1);
  assign last    = row_end && rows_left == (BUF_ADDR_WIDTH + 1)'(1);
  always_ff @(posedge clk)
    if (reset) begin
      bank      <= '0;
      row       <= '0;
      rows_left <= '0;
    end else if (load) begin
      bank      <= '0;
      row       <= base;
      rows_left <= num_rows;
    end else if (advance) begin
      bank      <= row_end ? '0 : bank + BW'(1);
      row       <= row_end ? row + BUF_ADDR_WIDTH'(1) : row;
      rows_left <= row_end ? rows_left - (BUF_ADDR_WIDTH + 1)'(1) : rows_left;
    end
endmodule

// File: rtl/wbuf_loader.sv
// wbuf_loader: scatters descriptor rows from a valid/ready stream across weight-buffer banks; ports cfg_*, s_*, busy/done, mem_write_*
module wbuf_loader
  import wbuf_params::*;
#(
  parameter int  MEM_DATA_WIDTH = 64,
  parameter int  ARRAY_N        = 64,
  parameter int  ARRAY_M        = 64,
  parameter int  DATA_WIDTH     = 16,
  parameter int  BUF_ADDR_WIDTH = 9,
  localparam int GROUP_SIZE     = group_size(ARRAY_M, DATA_WIDTH, MEM_DATA_WIDTH),
  localparam int NUM_BANKS      = num_banks(ARRAY_N, GROUP_SIZE),
  localparam int BUF_ID_W       = buf_id_w(ARRAY_N, GROUP_SIZE),
  localparam int MEM_ADDR_WIDTH = mem_addr_width(BUF_ADDR_WIDTH, BUF_ID_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic [BUF_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [BUF_ADDR_WIDTH:0]   cfg_num_rows,
  output logic                      busy,
  output logic                      done,
  input  logic                      s_valid,
  input  logic [MEM_DATA_WIDTH-1:0] s_data,
  output logic                      s_ready,
  output logic                      mem_write_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_data
);
  localparam int BW = BUF_ID_W == 0 ? 1 : BUF_ID_W;
  state_t                      state, next;
  logic                        accept, empty, beat, last;
  logic [BW-1:0]               bank;
  logic [BUF_ADDR_WIDTH-1:0]   row;
  logic [MEM_ADDR_WIDTH-1:0]   wr_addr;
  assign accept  = state == IDLE && cfg_start;
  assign empty   = cfg_num_rows == '0;
  assign beat    = s_valid && busy;
  assign s_ready = busy;
  always_comb next = state == IDLE ? (accept && !empty ? LOAD : IDLE) : (beat && last ? IDLE : LOAD);
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next;
      busy  <= next == LOAD;
      done  <= (accept && empty) || (beat && last);
    end
  wbuf_addr_gen #(
    .NUM_BANKS(NUM_BANKS),
    .BUF_ID_W(BUF_ID_W),
    .BUF_ADDR_WIDTH(BUF_ADDR_WIDTH)
  ) u_addr_gen (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .base(cfg_base_addr),
    .num_rows(cfg_num_rows),
    .advance(beat),
    .bank(bank),
    .row(row),
    .last(last)
  );
  // a single-bank buffer has no bank-ID field in the address
  if (BUF_ID_W == 0) begin : g_row
    assign wr_addr = row;
  end else begin : g_bank
    assign wr_addr = {row, bank[BUF_ID_W-1:0]};
  end
  register_sync #(.WIDTH(1)) u_req (
    .clk(clk), .reset(reset), .en(1'b1), .d(beat), .q(mem_write_req)
  );
  register_sync #(.WIDTH(MEM_ADDR_WIDTH)) u_addr (
    .clk(clk), .reset(reset), .en(beat), .d(wr_addr), .q(mem_write_addr)
  );
  register_sync #(.WIDTH(MEM_DATA_WIDTH)) u_data (
    .clk(clk), .reset(reset), .en(beat), .d(s_data), .q(mem_write_data)
  );
endmodule
